// File: rtl/hqm_AW_sync_pulse_tx_pkg.sv
// Shared types and parameter defaults for the pulse-crossing transmitter.
// The optional watchdog is enabled with HQM_AW_SYNC_PULSE_TX_TIMEOUT_EN.
package hqm_AW_sync_pulse_tx_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int TMO_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hqm_AW_sync_pulse_tx_state_t;

endpackage

// File: rtl/hqm_AW_sync1.sv
// Two-flop level synchronizer with async active-low reset on rstb.
module hqm_AW_sync1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability capture stage followed by the settled output stage.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= data;
            r_sync <= r_meta;
        end
    end

    assign data_sync = r_sync;

endmodule

// File: rtl/hqm_aw_sync_pulse_tx.sv
// Pulse-to-four-phase-handshake transmitter with a pending-event counter.
// Define HQM_AW_SYNC_PULSE_TX_TIMEOUT_EN to build the handshake watchdog.
module hqm_aw_sync_pulse_tx
    import hqm_AW_sync_pulse_tx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             ack_in,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    output logic             tmo
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (CNT_W < 1 || TMO_W < 1) begin : g_param_chk
        $error("hqm_aw_sync_pulse_tx: CNT_W and TMO_W must be at least 1");
    end

    hqm_AW_sync_pulse_tx_state_t r_state;
    hqm_AW_sync_pulse_tx_state_t w_state_nxt;
    logic [CNT_W-1:0]            r_pend;
    logic [CNT_W-1:0]            w_pend_nxt;
    logic                        r_req;
    logic                        r_busy;
    logic                        r_ovf;
    logic                        w_ack_sync;
    logic                        w_dec;
    logic                        w_drop;

    hqm_AW_sync1 #(
        .WIDTH (1)
    ) u_ack_sync (
        .clk       (clk),
        .rstb      (rst_n),
        .data      (ack_in),
        .data_sync (w_ack_sync)
    );

    // Handshake sequencing; leaving IDLE is what consumes one event.
    always_comb begin
        w_state_nxt = r_state;
        w_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend != '0 || pulse_in) begin
                    w_state_nxt = REQ;
                    w_dec       = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (w_ack_sync) begin
                    w_state_nxt = RELEASE;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            RELEASE: begin
                if (!w_ack_sync) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RELEASE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pending count: +pulse, -dispatch, drop new events only when full and not draining.
    always_comb begin
        w_pend_nxt = r_pend;
        w_drop     = 1'b0;
        if (pulse_in && !w_dec) begin
            if (r_pend == CNT_MAX) begin
                w_drop = 1'b1;
            end else begin
                w_pend_nxt = r_pend + CNT_W'(1);
            end
        end else if (!pulse_in && w_dec) begin
            w_pend_nxt = r_pend - CNT_W'(1);
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // State, count and all status outputs are registered from their next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_req   <= (w_state_nxt == REQ);
            r_busy  <= (w_state_nxt != IDLE) || (w_pend_nxt != '0);
            r_ovf   <= r_ovf | w_drop;
        end
    end

    assign req_out  = r_req;
    assign busy     = r_busy;
    assign pend_cnt = r_pend;
    assign ovf      = r_ovf;

`ifdef HQM_AW_SYNC_PULSE_TX_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    logic [TMO_W-1:0] r_wdog;
    logic [TMO_W-1:0] w_wdog_nxt;
    logic             r_tmo;

    // Watchdog only observes; it counts handshake cycles and saturates.
    always_comb begin
        if (w_state_nxt == IDLE) begin
            w_wdog_nxt = '0;
        end else if (r_state != IDLE && r_wdog != TMO_MAX) begin
            w_wdog_nxt = r_wdog + TMO_W'(1);
        end else begin
            w_wdog_nxt = r_wdog;
        end
    end

    // Sticky timeout flag raised when the watchdog hits its ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
            r_tmo  <= 1'b0;
        end else begin
            r_wdog <= w_wdog_nxt;
            r_tmo  <= r_tmo | (w_wdog_nxt == TMO_MAX);
        end
    end

    assign tmo = r_tmo;
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: doc/hqm_aw_sync_pulse_tx.md
# hqm_AW_sync_pulse_tx

Source-domain transmitter for single-bit clock-domain crossings. It accepts one-cycle event pulses in its own clock domain and queues them as a pending count. It sends each event to a remote domain as a four-phase req/ack level handshake, so the remote side only needs a plain double-flop synchronizer on `req`. The block is the sending end of the sync1-style crossing and is used wherever a pulse must cross into an unrelated clock without being lost.

## Interface
Parameters:
- `CNT_W`, default 4: width of the pending-event counter. Maximum pending count is 2^CNT_W-1.
- `TMO_W`, default 10: width of the handshake watchdog counter. Used only when the timeout feature is compiled in.

Ports:
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `pulse_in` input 1: one-cycle event strobe, one event per high cycle.
- `ack_in` input 1: acknowledge level from the remote domain. It is asynchronous to `clk` and is synchronized internally.
- `req_out` output 1: registered request level toward the remote domain.
- `busy` output 1: high when the FSM is not in IDLE or `pend_cnt` is non-zero.
- `pend_cnt` output CNT_W: number of events accepted but not yet dispatched.
- `ovf` output 1: sticky flag; an event was dropped at saturation.
- `tmo` output 1: sticky flag; the handshake watchdog expired.

## Operation
- `ack_sync` is `ack_in` passed through a two-flop synchronizer that is reset by `rst_n`.
- The FSM has three states: IDLE, REQ and RELEASE.
  - IDLE → REQ when `pend_cnt != 0` or `pulse_in == 1`.
  - REQ → RELEASE when `ack_sync == 1`.
  - RELEASE → IDLE when `ack_sync == 0`.
- `req_out` is a registered output and equals 1 exactly when the state is REQ.
- `pend_cnt` update rule: next = `pend_cnt + inc − dec`.
  - `inc` = `pulse_in`.
  - `dec` = 1 on the IDLE → REQ transition.
  - A simultaneous inc and dec leaves the count unchanged.
- A pulse arriving in IDLE while `pend_cnt == 0` is dispatched directly, and the count stays 0.
- Saturation: if `pend_cnt == 2^CNT_W-1`, `pulse_in == 1` and `dec == 0`, the event is dropped, the count holds and `ovf` is set.
- `ovf` and `tmo` are cleared only by `rst_n`.
- Reset while a handshake is in progress: state → IDLE, `req_out` → 0, pending events are discarded.
  - After a mid-handshake reset, the remote side must also be reset. This is a system-level requirement.

## Timing
- All outputs reset to 0: `req_out`, `busy`, `pend_cnt`, `ovf`, `tmo`. The `ack_sync` flops also reset to 0.
- Pulse to request latency: a pulse sampled at edge N in IDLE gives `req_out` = 1 after edge N+1.
- `ack_in` to `ack_sync` latency is 2 edges. A state change follows 1 edge after that.
- With `ack_in` tied to `req_out`, one event takes exactly 7 cycles. Back-to-back pending events produce a `req_out` rising edge every 7 cycles.
- `pulse_in` is accepted every cycle in every state. It is never back-pressured; events are only lost at saturation.
- `busy` is registered and is valid in the same cycle as the state and count it reflects.

## Configuration
- Macro: `HQM_AW_SYNC_PULSE_TX_TIMEOUT_EN`.
- Defined:
  - A TMO_W-bit watchdog counts cycles spent in REQ or RELEASE and is cleared on entry to IDLE.
  - When the watchdog reaches 2^TMO_W-1, it sets `tmo` and holds its value.
  - The FSM is unaffected and keeps waiting for the acknowledge.
- Undefined: no watchdog logic is present, and `tmo` is tied to 0.

## Structure
- Package `hqm_AW_sync_pulse_tx_pkg` contains:
  - the state enum `hqm_AW_sync_pulse_tx_state_t` (IDLE=2'd0, REQ=2'd1, RELEASE=2'd2);
  - the localparam defaults for `CNT_W` and `TMO_W`.
- The ack synchronizer is the one sub-module: an instance of `hqm_AW_sync1`, with clock `clk`, data `ack_in` and output `ack_sync`.
  - For reset it uses the library double-sync cell variant with `rstb` connected to `rst_n`.

## Test plan
- **Single pulse, loopback:** `ack_in` tied to `req_out`; one `pulse_in` at cycle 5 → `req_out` high on cycles 6–8, low from cycle 9; `busy` low from cycle 12.
- **Burst, loopback:** 5 consecutive pulses → `pend_cnt` peaks at 4; 5 `req_out` rising edges spaced 7 cycles apart; `ovf` = 0.
- **Saturation, `ack_in` held 0, CNT_W = 4:** 20 pulses → `pend_cnt` = 15, `ovf` = 1, `req_out` stuck at 1.
- **Simultaneous pulse and dispatch:** `pend_cnt` = 3, pulse arrives on the IDLE → REQ edge → `pend_cnt` stays 3.
- **Reset mid-handshake:** `rst_n` asserted asynchronously while in REQ with `pend_cnt` = 2 → all outputs 0 immediately; after release, the block stays idle until a new pulse.
- **Timeout, macro defined, TMO_W = 4, `ack_in` held 0:** one pulse → `tmo` = 1 after 15 cycles in REQ. With the macro undefined, `tmo` stays 0.
